// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer.
package pic_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } state_e;

  localparam int unsigned IC4     = 0;
  localparam int unsigned SNGL    = 1;
  localparam int unsigned ICW1_ID = 4;
  localparam int unsigned RIS     = 0;
  localparam int unsigned RR      = 1;
  localparam int unsigned P       = 2;
  localparam int unsigned SMM     = 5;
  localparam int unsigned ESMM    = 6;

  localparam logic [1:0] OCW2_SEL = 2'b00;
  localparam logic [1:0] OCW3_SEL = 2'b01;

  typedef struct packed {
    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic              a0;
    logic [DATA_W-1:0] data;
  } bus_smp_t;

  // Strobes idle high so a freshly reset synchroniser never fakes an edge.
  localparam bus_smp_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, a0: 1'b0, data: '0};

  function automatic logic is_icw1(input logic a0, input logic [DATA_W-1:0] d);
    return !a0 && d[ICW1_ID];
  endfunction

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU bus, core status and command register outputs of the PIC sequencer.
interface pic_cmd_sequencer_if;
  import pic_pkg::*;

  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic              a0;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] irr;
  logic [DATA_W-1:0] isr;
  logic [DATA_W-1:0] poll_vec;
  logic [DATA_W-1:0] icw1;
  logic [DATA_W-1:0] icw2;
  logic [DATA_W-1:0] icw3;
  logic [DATA_W-1:0] icw4;
  logic [DATA_W-1:0] imr;
  logic [DATA_W-1:0] ocw2;
  logic              ocw2_stb;
  logic [DATA_W-1:0] ocw3;
  logic              poll_stb;
  logic              smm;
  logic              init_done;
  logic              cmd_err;

  modport master (
    output cs_n, wr_n, rd_n, a0, data_in, irr, isr, poll_vec,
    input  data_out, data_oe, icw1, icw2, icw3, icw4, imr, ocw2, ocw2_stb,
           ocw3, poll_stb, smm, init_done, cmd_err
  );

  modport slave (
    input  cs_n, wr_n, rd_n, a0, data_in, irr, isr, poll_vec,
    output data_out, data_oe, icw1, icw2, icw3, icw4, imr, ocw2, ocw2_stb,
           ocw3, poll_stb, smm, init_done, cmd_err
  );

endinterface

// File: rtl/pic_bus_sync.sv
// Equal-depth synchroniser for all CPU bus inputs plus write/read edge detection.
module pic_bus_sync
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n_i,
  input  logic              wr_n_i,
  input  logic              rd_n_i,
  input  logic              a0_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_evt_c,
  output logic              rd_evt_c,
  output logic              rd_active_c,
  output logic              a0_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  bus_smp_t in_smp;
  bus_smp_t stage_q [SYNC_STAGES];
  logic     wr_prev_q;
  logic     rd_prev_q;

  assign in_smp = '{cs_n: cs_n_i, wr_n: wr_n_i, rd_n: rd_n_i, a0: a0_i, data: data_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= BUS_IDLE;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      stage_q[0] <= in_smp;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
      wr_prev_q <= stage_q[LAST].wr_n;
      rd_prev_q <= stage_q[LAST].rd_n;
    end
  end

  // Write acts on the trailing (rising) edge, read on the leading (falling) edge.
  assign wr_evt_c    = stage_q[LAST].wr_n & ~wr_prev_q & ~stage_q[LAST].cs_n;
  assign rd_evt_c    = ~stage_q[LAST].rd_n & rd_prev_q & ~stage_q[LAST].cs_n;
  assign rd_active_c = ~stage_q[LAST].rd_n & ~stage_q[LAST].cs_n;
  assign a0_o        = stage_q[LAST].a0;
  assign data_o      = stage_q[LAST].data;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259-style ICW/OCW command sequencer with registered status read-back.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          CASCADE_EN     = 1'b1,
  parameter bit          RESET_READ_RIS = 1'b0
) (
  input logic clk,
  input logic rst,
  pic_cmd_sequencer_if.slave bus_if
);

  logic              wr_evt_c, rd_evt_c, rd_active_c, a0_s;
  logic [DATA_W-1:0] data_s;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [DATA_W-1:0] imr_q, imr_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ocw2_stb_q, ocw2_stb_d, poll_stb_q, poll_stb_d, cmd_err_q, cmd_err_d;
  logic              smm_q, smm_d, read_sel_q, read_sel_d, poll_pending_q, poll_pending_d;
  logic              init_done_q, init_done_d, data_oe_q, data_oe_d;

  pic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .cs_n_i      (bus_if.cs_n),
    .wr_n_i      (bus_if.wr_n),
    .rd_n_i      (bus_if.rd_n),
    .a0_i        (bus_if.a0),
    .data_i      (bus_if.data_in),
    .wr_evt_c    (wr_evt_c),
    .rd_evt_c    (rd_evt_c),
    .rd_active_c (rd_active_c),
    .a0_o        (a0_s),
    .data_o      (data_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      icw1_q         <= '0;
      icw2_q         <= '0;
      icw3_q         <= '0;
      icw4_q         <= '0;
      imr_q          <= '0;
      ocw2_q         <= '0;
      ocw3_q         <= '0;
      data_out_q     <= '0;
      ocw2_stb_q     <= 1'b0;
      poll_stb_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
      smm_q          <= 1'b0;
      read_sel_q     <= RESET_READ_RIS;
      poll_pending_q <= 1'b0;
      init_done_q    <= 1'b0;
      data_oe_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      icw1_q         <= icw1_d;
      icw2_q         <= icw2_d;
      icw3_q         <= icw3_d;
      icw4_q         <= icw4_d;
      imr_q          <= imr_d;
      ocw2_q         <= ocw2_d;
      ocw3_q         <= ocw3_d;
      data_out_q     <= data_out_d;
      ocw2_stb_q     <= ocw2_stb_d;
      poll_stb_q     <= poll_stb_d;
      cmd_err_q      <= cmd_err_d;
      smm_q          <= smm_d;
      read_sel_q     <= read_sel_d;
      poll_pending_q <= poll_pending_d;
      init_done_q    <= init_done_d;
      data_oe_q      <= data_oe_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    icw1_d         = icw1_q;
    icw2_d         = icw2_q;
    icw3_d         = icw3_q;
    icw4_d         = icw4_q;
    imr_d          = imr_q;
    ocw2_d         = ocw2_q;
    ocw3_d         = ocw3_q;
    data_out_d     = data_out_q;
    ocw2_stb_d     = 1'b0;
    poll_stb_d     = 1'b0;
    cmd_err_d      = 1'b0;
    smm_d          = smm_q;
    read_sel_d     = read_sel_q;
    poll_pending_d = poll_pending_q;
    data_oe_d      = rd_active_c;

    // Reads sample only _q values, so a coincident write is never visible yet.
    if (rd_evt_c) begin
      if (a0_s) begin
        data_out_d = imr_q;
      end else if (poll_pending_q) begin
        data_out_d     = bus_if.poll_vec;
        poll_pending_d = 1'b0;
      end else begin
        data_out_d = read_sel_q ? bus_if.isr : bus_if.irr;
      end
    end

    if (wr_evt_c) begin
      if (is_icw1(a0_s, data_s)) begin
        icw1_d     = data_s;
        imr_d      = '0;
        smm_d      = 1'b0;
        read_sel_d = RESET_READ_RIS;
        if (!data_s[IC4]) icw4_d = '0;
        state_d    = ST_WAIT_ICW2;
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            if (a0_s) begin
              icw2_d = data_s;
              if (!icw1_q[SNGL] && CASCADE_EN) state_d = ST_WAIT_ICW3;
              else if (icw1_q[IC4])            state_d = ST_WAIT_ICW4;
              else                             state_d = ST_READY;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (a0_s) begin
              icw3_d  = data_s;
              state_d = icw1_q[IC4] ? ST_WAIT_ICW4 : ST_READY;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (a0_s && (data_s[7:5] == 3'b000)) begin
              icw4_d  = data_s;
              state_d = ST_READY;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          ST_READY: begin
            if (a0_s) begin
              imr_d = data_s;
            end else if (data_s[4:3] == OCW2_SEL) begin
              ocw2_d     = data_s;
              ocw2_stb_d = 1'b1;
            end else if (data_s[4:3] == OCW3_SEL) begin
              if (data_s[7]) begin
                cmd_err_d = 1'b1;
              end else begin
                ocw3_d = data_s;
                if (data_s[RR])   read_sel_d = data_s[RIS];
                if (data_s[ESMM]) smm_d      = data_s[SMM];
                if (data_s[P]) begin
                  poll_stb_d     = 1'b1;
                  poll_pending_d = 1'b1;
                end
              end
            end
          end
          default: cmd_err_d = 1'b1;
        endcase
      end
    end

    init_done_d = (state_d == ST_READY);
  end

  assign bus_if.data_out  = data_out_q;
  assign bus_if.data_oe   = data_oe_q;
  assign bus_if.icw1      = icw1_q;
  assign bus_if.icw2      = icw2_q;
  assign bus_if.icw3      = icw3_q;
  assign bus_if.icw4      = icw4_q;
  assign bus_if.imr       = imr_q;
  assign bus_if.ocw2      = ocw2_q;
  assign bus_if.ocw2_stb  = ocw2_stb_q;
  assign bus_if.ocw3      = ocw3_q;
  assign bus_if.poll_stb  = poll_stb_q;
  assign bus_if.smm       = smm_q;
  assign bus_if.init_done = init_done_q;
  assign bus_if.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Scenario bench for pic_cmd_sequencer; a second instance runs with CASCADE_EN=0.
module tb_pic_cmd_sequencer;
  import pic_pkg::*;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_cmd_sequencer_if bus0 ();
  pic_cmd_sequencer_if bus1 ();

  pic_cmd_sequencer #(.SYNC_STAGES(SYNC), .CASCADE_EN(1'b1), .RESET_READ_RIS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus_if(bus0.slave)
  );
  pic_cmd_sequencer #(.SYNC_STAGES(SYNC), .CASCADE_EN(1'b0), .RESET_READ_RIS(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .bus_if(bus1.slave)
  );

  assign bus1.cs_n     = bus0.cs_n;
  assign bus1.wr_n     = bus0.wr_n;
  assign bus1.rd_n     = bus0.rd_n;
  assign bus1.a0       = bus0.a0;
  assign bus1.data_in  = bus0.data_in;
  assign bus1.irr      = bus0.irr;
  assign bus1.isr      = bus0.isr;
  assign bus1.poll_vec = bus0.poll_vec;

  int n_pass  = 0;
  int n_total = 0;
  int err0 = 0, err1 = 0, ocw2c0 = 0, pollc0 = 0;
  logic [7:0] exp_q [$];

  // Pulse counters observed away from the active edge.
  always @(negedge clk) begin
    if (bus0.cmd_err)  err0++;
    if (bus1.cmd_err)  err1++;
    if (bus0.ocw2_stb) ocw2c0++;
    if (bus0.poll_stb) pollc0++;
  end

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus0.cs_n = 1'b0; bus0.a0 = a; bus0.data_in = d; bus0.wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    bus0.wr_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    bus0.cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic a, input logic [7:0] expv, input string name);
    bit seen = 1'b0;
    logic [7:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    bus0.cs_n = 1'b0; bus0.a0 = a; bus0.rd_n = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus0.data_oe) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_total++;
    if (!seen) $display("FAIL %s: data_oe never rose, expected data %h", name, e);
    else if (bus0.data_out !== e) $display("FAIL %s: data_out %h expected %h", name, bus0.data_out, e);
    else n_pass++;
    bus0.rd_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    n_total++;
    if (bus0.data_oe !== 1'b0) $display("FAIL %s_oe_off: data_oe %b expected 0", name, bus0.data_oe);
    else n_pass++;
    bus0.cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({bus0.icw1, bus0.icw2, bus0.icw3, bus0.icw4, bus0.imr, bus0.ocw2, bus0.ocw3, bus0.data_out} !== 64'h0)
      $display("FAIL reset_regs: icw1 %h icw2 %h imr %h data_out %h expected all 0",
               bus0.icw1, bus0.icw2, bus0.imr, bus0.data_out);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    n_total++;
    if ({bus0.init_done, bus0.cmd_err, bus0.ocw2_stb, bus0.poll_stb, bus0.smm, bus0.data_oe} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {bus0.init_done, bus0.cmd_err, bus0.ocw2_stb, bus0.poll_stb, bus0.smm, bus0.data_oe});
    else n_pass++;
    n_total++;
    if (err0 !== 0) $display("FAIL reset_no_err: cmd_err pulses %0d expected 0", err0);
    else n_pass++;
  endtask

  task automatic test_single();
    int e;
    apply_reset();
    e = err0;
    bus_write(1'b0, 8'h12, 2);
    n_total++;
    if (bus0.icw1 !== 8'h12 || bus0.init_done !== 1'b0)
      $display("FAIL single_icw1: icw1 %h init_done %b expected 12/0", bus0.icw1, bus0.init_done);
    else n_pass++;
    bus_write(1'b1, 8'h08, 2);
    n_total++;
    if (bus0.icw2 !== 8'h08) $display("FAIL single_icw2: icw2 %h expected 08", bus0.icw2);
    else n_pass++;
    n_total++;
    if (bus0.init_done !== 1'b1) $display("FAIL single_done: init_done %b expected 1", bus0.init_done);
    else n_pass++;
    n_total++;
    if (bus0.icw4 !== 8'h00) $display("FAIL single_icw4: icw4 %h expected 00", bus0.icw4);
    else n_pass++;
    n_total++;
    if (err0 !== e) $display("FAIL single_no_err: cmd_err pulses %0d expected %0d", err0, e);
    else n_pass++;
  endtask

  task automatic test_cascade();
    apply_reset();
    bus_write(1'b0, 8'h11, 2);
    bus_write(1'b1, 8'h20, 2);
    bus_write(1'b1, 8'h04, 2);
    n_total++;
    if (bus0.init_done !== 1'b0) $display("FAIL casc_not_ready3: init_done %b expected 0", bus0.init_done);
    else n_pass++;
    n_total++;
    if (bus1.init_done !== 1'b1 || bus1.icw4 !== 8'h04 || bus1.icw3 !== 8'h00)
      $display("FAIL nocasc_ready3: init_done %b icw4 %h icw3 %h expected 1/04/00",
               bus1.init_done, bus1.icw4, bus1.icw3);
    else n_pass++;
    bus_write(1'b1, 8'h01, 2);
    n_total++;
    if (bus0.init_done !== 1'b1) $display("FAIL casc_ready4: init_done %b expected 1", bus0.init_done);
    else n_pass++;
    n_total++;
    if (bus0.icw3 !== 8'h04 || bus0.icw4 !== 8'h01)
      $display("FAIL casc_words: icw3 %h icw4 %h expected 04/01", bus0.icw3, bus0.icw4);
    else n_pass++;
    n_total++;
    if (bus1.imr !== 8'h01 || err1 !== 0)
      $display("FAIL nocasc_imr: imr %h errs %0d expected 01/0", bus1.imr, err1);
    else n_pass++;
  endtask

  task automatic test_restart();
    int e;
    apply_reset();
    bus_write(1'b0, 8'h12, 2);
    bus_write(1'b1, 8'h08, 2);
    bus_write(1'b1, 8'hFF, 2);
    n_total++;
    if (bus0.imr !== 8'hFF) $display("FAIL restart_imr_set: imr %h expected ff", bus0.imr);
    else n_pass++;
    bus_write(1'b0, 8'h11, 2);
    bus_write(1'b1, 8'h20, 2);
    bus_write(1'b0, 8'h13, 2);
    n_total++;
    if (bus0.imr !== 8'h00 || bus0.init_done !== 1'b0 || bus0.icw1 !== 8'h13)
      $display("FAIL restart_icw1: imr %h init_done %b icw1 %h expected 00/0/13",
               bus0.imr, bus0.init_done, bus0.icw1);
    else n_pass++;
    bus_write(1'b1, 8'h40, 2);
    n_total++;
    if (bus0.icw2 !== 8'h40 || bus0.init_done !== 1'b0)
      $display("FAIL restart_icw2: icw2 %h init_done %b expected 40/0", bus0.icw2, bus0.init_done);
    else n_pass++;
    e = err0;
    bus_write(1'b1, 8'hE1, 2);
    n_total++;
    if (err0 !== e + 1 || bus0.icw4 !== 8'h00 || bus0.init_done !== 1'b0)
      $display("FAIL bad_icw4: errs %0d icw4 %h init_done %b expected %0d/00/0",
               err0, bus0.icw4, bus0.init_done, e + 1);
    else n_pass++;
    bus_write(1'b1, 8'h01, 2);
    n_total++;
    if (bus0.icw4 !== 8'h01 || bus0.init_done !== 1'b1)
      $display("FAIL good_icw4: icw4 %h init_done %b expected 01/1", bus0.icw4, bus0.init_done);
    else n_pass++;
    bus_write(1'b0, 8'h12, 2);
    n_total++;
    if (bus0.icw4 !== 8'h00) $display("FAIL icw4_clear: icw4 %h expected 00", bus0.icw4);
    else n_pass++;
    bus_write(1'b1, 8'h08, 2);
  endtask

  task automatic test_reads();
    int e;
    bus_write(1'b1, 8'hA5, 2);
    bus_read(1'b1, 8'hA5, "rd_imr");
    bus_read(1'b0, 8'h3C, "rd_irr");
    bus_write(1'b0, 8'h0B, 2);
    n_total++;
    if (bus0.ocw3 !== 8'h0B) $display("FAIL ocw3_0b: ocw3 %h expected 0b", bus0.ocw3);
    else n_pass++;
    bus_read(1'b0, 8'hC3, "rd_isr");
    e = pollc0;
    bus_write(1'b0, 8'h0C, 2);
    n_total++;
    if (pollc0 !== e + 1) $display("FAIL poll_stb: pulses %0d expected %0d", pollc0, e + 1);
    else n_pass++;
    bus_read(1'b0, 8'h85, "rd_poll");
    bus_read(1'b0, 8'hC3, "rd_after_poll");
    bus_write(1'b0, 8'h68, 2);
    n_total++;
    if (bus0.smm !== 1'b1) $display("FAIL smm_set: smm %b expected 1", bus0.smm);
    else n_pass++;
  endtask

  task automatic test_strobe();
    int e, first;
    e = ocw2c0;
    first = 0;
    @(negedge clk);
    bus0.cs_n = 1'b0; bus0.a0 = 1'b0; bus0.data_in = 8'h20; bus0.wr_n = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (ocw2c0 !== e) $display("FAIL ocw2_early: pulses %0d expected %0d while wr_n low", ocw2c0, e);
    else n_pass++;
    bus0.wr_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus0.ocw2_stb && first == 0) first = i;
    end
    bus0.cs_n = 1'b1;
    n_total++;
    if (first !== int'(SYNC) + 1) $display("FAIL ocw2_latency: cycles %0d expected %0d", first, int'(SYNC) + 1);
    else n_pass++;
    n_total++;
    if (ocw2c0 !== e + 1 || bus0.ocw2 !== 8'h20)
      $display("FAIL ocw2_pulse: pulses %0d ocw2 %h expected %0d/20", ocw2c0, bus0.ocw2, e + 1);
    else n_pass++;
    e = err0;
    bus_write(1'b0, 8'h88, 2);
    n_total++;
    if (err0 !== e + 1 || bus0.ocw3 !== 8'h68)
      $display("FAIL ocw3_bad: errs %0d ocw3 %h expected %0d/68", err0, bus0.ocw3, e + 1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    logic [7:0] e;
    @(negedge clk);
    bus0.cs_n = 1'b0; bus0.a0 = 1'b1; bus0.data_in = 8'h5A; bus0.wr_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'hA5);
    bus0.wr_n = 1'b1; bus0.rd_n = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus0.data_oe) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_total++;
    if (!seen) $display("FAIL b2b_read: data_oe never rose, expected data %h", e);
    else if (bus0.data_out !== e) $display("FAIL b2b_read: data_out %h expected %h", bus0.data_out, e);
    else n_pass++;
    n_total++;
    if (bus0.imr !== 8'h5A) $display("FAIL b2b_write: imr %h expected 5a", bus0.imr);
    else n_pass++;
    bus0.rd_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    bus0.cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int e;
    apply_reset();
    bus_write(1'b0, 8'h11, 2);
    bus_write(1'b1, 8'h20, 2);
    n_total++;
    if (bus0.icw2 !== 8'h20) $display("FAIL mid_pre: icw2 %h expected 20", bus0.icw2);
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++;
    if ({bus0.icw1, bus0.icw2, bus0.imr, bus0.init_done, bus0.cmd_err, bus0.data_oe} !== 27'h0)
      $display("FAIL mid_async: icw1 %h icw2 %h imr %h init_done %b expected zeros",
               bus0.icw1, bus0.icw2, bus0.imr, bus0.init_done);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    e = err0;
    bus_write(1'b1, 8'h04, 2);
    n_total++;
    if (err0 !== e + 1 || bus0.icw3 !== 8'h00 || bus0.init_done !== 1'b0)
      $display("FAIL mid_idle_err: errs %0d icw3 %h init_done %b expected %0d/00/0",
               err0, bus0.icw3, bus0.init_done, e + 1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus0.cs_n = 1'b1; bus0.wr_n = 1'b1; bus0.rd_n = 1'b1; bus0.a0 = 1'b0;
    bus0.data_in = 8'h00;
    bus0.irr = 8'h3C; bus0.isr = 8'hC3; bus0.poll_vec = 8'h85;
    test_reset();
    test_single();
    test_cascade();
    test_restart();
    test_reads();
    test_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
- Parametrised, clocked successor to the 8259-style read/write command logic.
- Synchronises the CPU bus strobes and sequences ICW1..ICW4 initialisation.
- After initialisation, decodes OCW1/OCW2/OCW3 and serves status reads of IMR, IRR and ISR, including poll.
- Sits between the CPU data-bus buffer and the PIC priority/in-service core.

Parameters:
- SYNC_STAGES, 2, flop stages applied to every bus input: wr_n, rd_n, cs_n, a0 and data_in, all delayed equally so they stay aligned.
- CASCADE_EN, 1, 1 = honour ICW1.SNGL; 0 = treat every ICW1 as single mode, so ICW3 is never expected.
- RESET_READ_RIS, 0, read select loaded at reset and at ICW1 (0 = IRR, 1 = ISR).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cs_n, wr_n, rd_n, a0  in  1 each  CPU bus controls, asynchronous
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data
- data_oe  out  1  read-drive enable
- irr, isr  in  8 each  status from the priority core
- poll_vec  in  8  poll response word from the core
- icw1, icw2, icw3, icw4  out  8 each  initialisation words
- imr  out  8  OCW1 mask
- ocw2  out  8  last OCW2
- ocw2_stb  out  1  one-cycle pulse when OCW2 is written
- ocw3  out  8  last valid OCW3
- poll_stb  out  1  one-cycle pulse when an OCW3 write has P=1
- smm  out  1  special mask mode
- init_done  out  1  high in READY
- cmd_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs 0 except read_sel=RESET_READ_RIS.
  - FSM = IDLE; synchroniser flops cleared.
  - Applies mid-sequence; no partial word survives.
- Event detection:
  - Write event: synced wr_n rises (0 to 1) with synced cs_n=0.
  - Read event: synced rd_n falls with synced cs_n=0.
  - Latency from the pin edge to register update is SYNC_STAGES+1 clk cycles.
  - Write and read events in the same cycle: both act. The read returns pre-write register values.
- ICW1 (a0=0, d[4]=1), accepted in any state:
  - icw1<=d; imr<=0; smm<=0; read_sel<=RESET_READ_RIS; init_done<=0.
  - If d[0]=0 (IC4 clear), icw4<=0.
  - Next state = WAIT_ICW2. This restarts any sequence in progress.
- FSM states: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - WAIT_ICW2, a0=1: icw2<=d. Next state is WAIT_ICW3 if SNGL=0 and CASCADE_EN=1; otherwise WAIT_ICW4 if IC4=1; otherwise READY.
  - WAIT_ICW3, a0=1: icw3<=d. Next state is WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4, a0=1 with d[7:5]=000: icw4<=d, next state READY.
  - WAIT_ICW4, a0=1 with d[7:5]!=000: cmd_err, stay in WAIT_ICW4.
  - Any WAIT state, a0=0 with a non-ICW1 word: cmd_err, state unchanged.
  - IDLE, any non-ICW1 write: cmd_err, stay in IDLE.
- READY writes:
  - a0=1: imr<=d.
  - a0=0, d[4:3]=00: ocw2<=d; ocw2_stb=1 for one cycle.
  - a0=0, d[4:3]=01, d[7]=0: ocw3<=d. If RR (d[1])=1, read_sel<=RIS (d[0]). If ESMM (d[6])=1, smm<=SMM (d[5]). If P (d[2])=1, poll_stb=1 and poll_pending<=1.
  - a0=0, d[4:3]=01, d[7]=1: cmd_err; no register changes.
- Reads (any state; data_out registered on the read event):
  - a0=1: data_out=imr.
  - a0=0 with poll_pending=1: data_out=poll_vec, then poll_pending<=0.
  - a0=0 otherwise: data_out=isr if read_sel=1, else irr.
  - data_oe=1 while synced rd_n=0 and cs_n=0; data_oe=0 the cycle after rd_n rises.
- init_done=1 exactly while the FSM is in READY.
- Strobe pulses (ocw2_stb, poll_stb, cmd_err) never exceed one cycle, even when the bus strobe is held low for many cycles.

Decomposition:
- Package pic_pkg:
  - FSM state enum.
  - Bit-index constants: IC4=0, SNGL=1, ICW1_ID=4, RIS=0, RR=1, P=2, SMM=5, ESMM=6.
  - OCW select codes 2'b00 and 2'b01.
- One sub-module: pic_bus_sync, a SYNC_STAGES-deep synchroniser plus edge detector producing wr_evt, rd_evt, rd_active and aligned a0/data.

Test Plan:
- Single mode, no ICW4: ICW1=0x12, ICW2=0x08 -> icw2=0x08, init_done=1, icw4=0, no cmd_err.
- Cascade with ICW4: 0x11, 0x20, 0x04, 0x01 -> icw3=0x04, icw4=0x01, READY only after the 4th write. Repeat with CASCADE_EN=0 -> READY after 3 writes and icw3 unchanged.
- Restart: ICW1 0x11, ICW2 0x20, then ICW1 0x13 -> state WAIT_ICW2, imr=0. Invalid ICW4 0xE1 -> cmd_err pulse, stays WAIT_ICW4.
- READY reads: OCW1=0xA5 -> a0=1 read gives 0xA5. OCW3=0x0B, then a0=0 read -> data_out=isr. OCW3=0x0C -> poll_stb; next a0=0 read gives poll_vec, the following read gives isr.
- Stimulus: OCW2=0x20 -> ocw2_stb exactly one cycle with wr_n held low for 10 cycles. OCW3=0x88 -> cmd_err, ocw3 unchanged.
- Assert rst during WAIT_ICW3 -> all outputs 0 immediately (asynchronous), FSM=IDLE, and a following ICW2-type write gives cmd_err.
